// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole board: grid size, debounce
// timing default and the per-button debounce state encoding.
package whack_pkg;

  localparam int N_BTN         = 9;
  localparam int STABLE_CYCLES = 50000;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    RISING    = 2'd1,
    STABLE_HI = 2'd2,
    FALLING   = 2'd3
  } db_state_t;

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle between the debouncer (slave) and the game FSM (master):
// raw buttons and hit clears in, clean levels, press pulses and hit flags out.
interface btn_debounce_if #(
  parameter int N_BTN = whack_pkg::N_BTN,
  parameter int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] hit_clr;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_hit;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;

  modport master (
    output btn_raw, hit_clr,
    input  btn_level, btn_press, btn_hit, hit_any, hit_idx
  );

  modport slave (
    input  btn_raw, hit_clr,
    output btn_level, btn_press, btn_hit, hit_any, hit_idx
  );

endinterface

// File: rtl/debounce_cell.sv
// One button: 2-flop synchronizer, then a 4-state debounce FSM with a
// saturating counter producing a clean level and a one-cycle press pulse.
module debounce_cell #(
  parameter int STABLE_CYCLES = whack_pkg::STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  import whack_pkg::*;

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here uses <= so all flops sample the pre-edge
  // values; blocking assignments would let s2 see this cycle's s1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= btn_raw;
      s2    <= s1;
      press <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (s2) begin
            state <= RISING;
            cnt   <= '0;
          end
        end
        RISING: begin
          if (!s2) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= STABLE_HI;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s2) begin
            state <= FALLING;
            cnt   <= '0;
          end
        end
        FALLING: begin
          // Level stays high until the release is accepted.
          if (s2) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= STABLE_LO;
            level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= STABLE_LO;
      endcase
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Debounces all mole buttons and keeps sticky hit flags so the slow game FSM
// can observe presses that last only one 5 MHz cycle.
module btn_debounce #(
  parameter int N_BTN         = whack_pkg::N_BTN,
  parameter int STABLE_CYCLES = whack_pkg::STABLE_CYCLES,
  parameter int IDX_W         = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic           clk,
  input  logic           rst,
  btn_debounce_if.slave  bus
);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] hit;
  logic [IDX_W-1:0] idx;

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    debounce_cell #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (bus.btn_raw[i]),
      .level   (level[i]),
      .press   (press[i])
    );
  end

  // A press landing in the same cycle as its clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit <= '0;
    end else begin
      hit <= press | (hit & ~bus.hit_clr);
    end
  end

  // NOTE: idx gets a default before the loop so every path assigns it and
  // no latch is inferred when no hit bit is set.
  always_comb begin
    idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (hit[i]) idx = IDX_W'(i);
    end
  end

  assign bus.btn_level = level;
  assign bus.btn_press = press;
  assign bus.btn_hit   = hit;
  assign bus.hit_any   = |hit;
  assign bus.hit_idx   = idx;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed plus randomized check of btn_debounce against a run-length
// reference model of the debounce rules (N_BTN=9, STABLE_CYCLES=4).
`timescale 1ns/1ps
module tb_btn_debounce;

  localparam int N  = 9;
  localparam int SC = 4;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;

  always #100 clk = ~clk;

  btn_debounce_if #(.N_BTN(N), .IDX_W(IW)) bus ();

  btn_debounce #(
    .N_BTN         (N),
    .STABLE_CYCLES (SC),
    .IDX_W         (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw samples pass through a 2-deep delay; a button's
  // accepted level flips once the delayed sample has disagreed with it for
  // SC+1 consecutive edges.
  bit [N-1:0] m_p1, m_p2, m_level, m_press, m_hit;
  int         m_run [N];

  task automatic model_edge();
    bit [N-1:0] nxt_press;
    bit [N-1:0] nxt_hit;
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_level = '0; m_press = '0; m_hit = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      nxt_press = '0;
      nxt_hit   = m_press | (m_hit & ~bus.hit_clr);
      for (int i = 0; i < N; i++) begin
        if (m_p2[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == SC + 1) begin
            m_level[i]   = ~m_level[i];
            nxt_press[i] = m_level[i];
            m_run[i]     = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_p2    = m_p1;
      m_p1    = bus.btn_raw;
      m_press = nxt_press;
      m_hit   = nxt_hit;
    end
  endtask

  function automatic logic [IW-1:0] lowest(bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return IW'(i);
    return '0;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("level", 32'(bus.btn_level), 32'(m_level));
    check("press", 32'(bus.btn_press), 32'(m_press));
    check("hit",   32'(bus.btn_hit),   32'(m_hit));
    check("any",   32'(bus.hit_any),   32'(|m_hit));
    check("idx",   32'(bus.hit_idx),   32'(lowest(m_hit)));
  endtask

  task automatic step(int n);
    repeat (n) begin
      model_edge();
      @(posedge clk);
      #1;
      check_model();
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.btn_raw = '0;
    bus.hit_clr = '0;
    step(3);
    check("rst_level", 32'(bus.btn_level), 32'h0);
    check("rst_hit",   32'(bus.btn_hit),   32'h0);
    check("rst_idx",   32'(bus.hit_idx),   32'h0);
    rst = 1'b0;
    step(2);

    // Clean press: accepted at the 7th edge after the raw change is applied.
    bus.btn_raw[3] = 1'b1;
    step(6);
    check("clean_early_level", 32'(bus.btn_level), 32'h0);
    step(1);
    check("clean_level", 32'(bus.btn_level), 32'h008);
    check("clean_press", 32'(bus.btn_press), 32'h008);
    step(1);
    check("clean_press_gone", 32'(bus.btn_press), 32'h0);
    check("clean_hit",        32'(bus.btn_hit),   32'h008);
    check("clean_idx",        32'(bus.hit_idx),   32'd3);
    check("clean_any",        32'(bus.hit_any),   32'd1);
    bus.hit_clr[3] = 1'b1;
    step(1);
    bus.hit_clr = '0;
    check("clr3_hit", 32'(bus.btn_hit), 32'h0);
    bus.btn_raw[3] = 1'b0;
    step(10);

    // Bounce rejection on button 0.
    bus.btn_raw[0] = 1'b1; step(2);
    bus.btn_raw[0] = 1'b0; step(2);
    bus.btn_raw[0] = 1'b1; step(2);
    bus.btn_raw[0] = 1'b0; step(10);
    check("bounce_level", 32'(bus.btn_level), 32'h0);
    check("bounce_hit",   32'(bus.btn_hit),   32'h0);

    // Short release while held: level stays, no second pulse.
    bus.btn_raw[0] = 1'b1;
    step(7);
    check("held_press", 32'(bus.btn_press), 32'h001);
    step(1);
    bus.hit_clr[0] = 1'b1;
    step(1);
    bus.hit_clr = '0;
    bus.btn_raw[0] = 1'b0; step(3);
    bus.btn_raw[0] = 1'b1; step(8);
    check("held_level", 32'(bus.btn_level), 32'h001);
    check("held_no_repress", 32'(bus.btn_hit), 32'h0);
    bus.btn_raw[0] = 1'b0;
    step(10);
    check("held_released", 32'(bus.btn_level), 32'h0);

    // Set/clear collision on button 5.
    bus.btn_raw[5] = 1'b1;
    step(7);
    check("coll_press", 32'(bus.btn_press), 32'h020);
    bus.hit_clr[5] = 1'b1;
    step(1);
    bus.hit_clr = '0;
    check("coll_hit", 32'(bus.btn_hit), 32'h020);
    bus.hit_clr[5] = 1'b1;
    step(1);
    bus.hit_clr = '0;
    check("coll_cleared", 32'(bus.btn_hit), 32'h0);
    check("coll_any",     32'(bus.hit_any), 32'd0);
    bus.btn_raw[5] = 1'b0;
    step(10);

    // Simultaneous presses on buttons 7 and 2.
    bus.btn_raw[7] = 1'b1;
    bus.btn_raw[2] = 1'b1;
    step(7);
    check("multi_press", 32'(bus.btn_press), 32'h084);
    step(1);
    check("multi_idx", 32'(bus.hit_idx), 32'd2);
    bus.hit_clr[2] = 1'b1;
    step(1);
    bus.hit_clr = '0;
    check("multi_idx_after_clr", 32'(bus.hit_idx), 32'd7);
    bus.btn_raw = '0;
    bus.hit_clr = '1;
    step(1);
    bus.hit_clr = '0;
    step(10);

    // Reset mid-debounce abandons the press; held input is re-accepted.
    bus.btn_raw[1] = 1'b1;
    step(4);
    rst = 1'b1;
    step(2);
    check("rstmid_level", 32'(bus.btn_level), 32'h0);
    check("rstmid_press", 32'(bus.btn_press), 32'h0);
    check("rstmid_hit",   32'(bus.btn_hit),   32'h0);
    rst = 1'b0;
    step(6);
    check("rstmid_early", 32'(bus.btn_press), 32'h0);
    step(1);
    check("rstmid_press_after", 32'(bus.btn_press), 32'h002);
    check("rstmid_level_after", 32'(bus.btn_level), 32'h002);
    bus.btn_raw = '0;
    step(10);

    // Randomized phase: independent toggling buttons, random clears.
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) bus.btn_raw[b] = ~bus.btn_raw[b];
      end
      bus.hit_clr = N'($urandom & $urandom);
      rst = (c >= 300 && c < 302);
      step(1);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
